// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and helpers for the multi-port register file.
//   REGFILE_WIDTH / REGFILE_DEPTH : default datapath width and register count
//   XZR_INDEX                     : index of the hard-wired zero register at defaults
//   addr_w(depth)                 : address width, never less than 1 bit
package regfile_pkg;

  localparam int REGFILE_WIDTH = 64;
  localparam int REGFILE_DEPTH = 32;
  localparam int XZR_INDEX     = 31;

  // Smallest w >= 1 with 2**w >= depth; a one-entry file still needs a 1-bit index.
  function automatic int addr_w(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
//   One independent read port of the register file.
//   clk, reset  : clock and asynchronous active-high reset (used only when READ_LAT=1)
//   i_mem       : flattened storage, entry i at i_mem[i]
//   i_pending   : outstanding-write scoreboard, one bit per register
//   i_wr_en/i_wr_addr/i_wr_data : this cycle's writeback, used for bypass
//   i_rd_addr   : register index to read
//   o_rd_data   : read value (0 for zero register / out-of-range)
//   o_rd_ready  : 1 when o_rd_data is architecturally current
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int READ_LAT = 0,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DEPTH-1:0][WIDTH-1:0] i_mem,
  input  logic [DEPTH-1:0]            i_pending,
  input  logic                        i_wr_en,
  input  logic [AW-1:0]               i_wr_addr,
  input  logic [WIDTH-1:0]            i_wr_data,
  input  logic [AW-1:0]               i_rd_addr,
  output logic [WIDTH-1:0]            o_rd_data,
  output logic                        o_rd_ready
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(DEPTH - 1);

  logic             w_oob;
  logic             w_is_zero;
  logic             w_hit;
  logic [WIDTH-1:0] w_mem_val;
  logic             w_mem_pend;
  logic [WIDTH-1:0] w_data;
  logic             w_ready;

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  assign w_oob     = ({1'b0, i_rd_addr} >= (AW + 1)'(DEPTH));
  assign w_is_zero = (ZERO_REG != 0) && (i_rd_addr == ZERO_IDX);
  assign w_hit     = i_wr_en && (i_wr_addr == i_rd_addr);

  // DEPTH:1 AND-OR mux; only in-range indices can select, so no array overrun.
  always_comb begin
    w_mem_val  = '0;
    w_mem_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_val  = w_mem_val  | (i_mem[i] & {WIDTH{i_rd_addr == AW'(i)}});
      w_mem_pend = w_mem_pend | (i_pending[i] & (i_rd_addr == AW'(i)));
    end
  end

  // Priority: forced zero, then same-cycle bypass, then storage.
  always_comb begin
    w_data  = '0;
    w_ready = 1'b1;
    if (w_oob || w_is_zero) begin
      w_data  = '0;
      w_ready = 1'b1;
    end else if (w_hit) begin
      w_data  = i_wr_data;
      w_ready = 1'b1;
    end else begin
      w_data  = w_mem_val;
      w_ready = !w_mem_pend;
    end
  end

  if (READ_LAT != 0) begin : g_reg
    logic [WIDTH-1:0] r_data;
    logic             r_ready;

    // Registered read stage: resets to "zero and ready".
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_data  <= '0;
        r_ready <= 1'b1;
      end else begin
        r_data  <= w_data;
        r_ready <= w_ready;
      end
    end

    assign o_rd_data  = r_data;
    assign o_rd_ready = r_ready;
  end else begin : g_comb
    logic w_unused_clk;
    assign w_unused_clk = clk | reset;
    assign o_rd_data    = w_data;
    assign o_rd_ready   = w_ready;
  end

endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass
//   Multi-port register file with write bypass, optional zero register,
//   optional registered reads and a per-register pending scoreboard.
//   clk, reset          : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data : writeback port (clears pending)
//   iss_en/iss_addr     : issue of a new producer (sets pending)
//   rd_addr[p]          : read index for port p
//   rd_data[p]          : read value for port p
//   rd_ready[p]         : 1 when rd_data[p] is architecturally current
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int READ_LAT = 0,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        iss_en,
  input  logic [AW-1:0]               iss_addr,
  input  logic [NREAD-1:0][AW-1:0]    rd_addr,
  output logic [NREAD-1:0][WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]            rd_ready
);

  localparam logic [AW-1:0] ZERO_IDX = AW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_pending;
  logic                        w_wr_ok;
  logic                        w_iss_ok;

  // Writes/issues to the zero register or past the end are dropped entirely.
  assign w_wr_ok  = wr_en && ({1'b0, wr_addr} < (AW + 1)'(DEPTH))
                    && !((ZERO_REG != 0) && (wr_addr == ZERO_IDX));
  assign w_iss_ok = iss_en && ({1'b0, iss_addr} < (AW + 1)'(DEPTH))
                    && !((ZERO_REG != 0) && (iss_addr == ZERO_IDX));

  // Register storage with decoded write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_ok && (wr_addr == AW'(i))) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  // Pending scoreboard; a same-cycle issue beats the write because it names a newer producer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_iss_ok && (iss_addr == AW'(i))) begin
          r_pending[i] <= 1'b1;
        end else if (w_wr_ok && (wr_addr == AW'(i))) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .READ_LAT (READ_LAT)
    ) u_port (
      .clk        (clk),
      .reset      (reset),
      .i_mem      (r_mem),
      .i_pending  (r_pending),
      .i_wr_en    (wr_en),
      .i_wr_addr  (wr_addr),
      .i_wr_data  (wr_data),
      .i_rd_addr  (rd_addr[p]),
      .o_rd_data  (rd_data[p]),
      .o_rd_ready (rd_ready[p])
    );
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass
//   Three instances: A0 (defaults, XZR on, combinational), A1 (XZR off,
//   shares A0's inputs) and B (DEPTH=24, NREAD=4, registered reads).
//   A behavioural model (arrays of values and pending flags) predicts all outputs.
module tb_regfile_bypass;

  logic clk;
  logic reset;

  // Group A: shared by A0 and A1
  logic                  wr_en, iss_en;
  logic [4:0]            wr_addr, iss_addr;
  logic [63:0]           wr_data;
  logic [1:0][4:0]       rd_addr;
  logic [1:0][63:0]      a0_data, a1_data;
  logic [1:0]            a0_rdy, a1_rdy;

  // Group B
  logic                  b_wr_en, b_iss_en;
  logic [4:0]            b_wr_addr, b_iss_addr;
  logic [63:0]           b_wr_data;
  logic [3:0][4:0]       b_rd_addr;
  logic [3:0][63:0]      b_data;
  logic [3:0]            b_rdy;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem_a [32];
  logic        pend_a [32];
  logic [63:0] mem_b [32];
  logic        pend_b [32];
  logic [63:0] eb_data [4];
  logic        eb_rdy [4];

  regfile_bypass u_a0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_data(a0_data), .rd_ready(a0_rdy)
  );

  regfile_bypass #(.ZERO_REG(0)) u_a1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_data(a1_data), .rd_ready(a1_rdy)
  );

  regfile_bypass #(.DEPTH(24), .NREAD(4), .READ_LAT(1)) u_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .rd_addr(b_rd_addr), .rd_data(b_data), .rd_ready(b_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural read rule: forced zero, then bypass, then stored value.
  function automatic void exp_read(input logic [63:0] m [32], input logic pd [32],
                                   input int depth, input bit zr, input logic we,
                                   input logic [4:0] wa, input logic [63:0] wd,
                                   input logic [4:0] ra, output logic [63:0] d, output logic r);
    if (int'(ra) >= depth || (zr && int'(ra) == depth - 1)) begin
      d = 64'd0; r = 1'b1;
    end else if (we && wa == ra) begin
      d = wd; r = 1'b1;
    end else begin
      d = m[ra]; r = !pd[ra];
    end
  endfunction

  task automatic clr_models();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 64'd0; pend_a[i] = 1'b0;
      mem_b[i] = 64'd0; pend_b[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; iss_en = 1'b0; wr_addr = 5'd0; iss_addr = 5'd0; wr_data = 64'd0;
    b_wr_en = 1'b0; b_iss_en = 1'b0; b_wr_addr = 5'd0; b_iss_addr = 5'd0; b_wr_data = 64'd0;
  endtask

  // One clock: check combinational A outputs, advance the model, check registered B outputs.
  task automatic do_cycle();
    logic [63:0] d;
    logic        r;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      exp_read(mem_a, pend_a, 32, 1'b1, wr_en, wr_addr, wr_data, rd_addr[p], d, r);
      chk($sformatf("a0_data[%0d]", p), a0_data[p], d);
      chk($sformatf("a0_rdy[%0d]", p), 64'(a0_rdy[p]), 64'(r));
      exp_read(mem_a, pend_a, 32, 1'b0, wr_en, wr_addr, wr_data, rd_addr[p], d, r);
      chk($sformatf("a1_data[%0d]", p), a1_data[p], d);
      chk($sformatf("a1_rdy[%0d]", p), 64'(a1_rdy[p]), 64'(r));
    end
    for (int p = 0; p < 4; p++) begin
      exp_read(mem_b, pend_b, 24, 1'b1, b_wr_en, b_wr_addr, b_wr_data, b_rd_addr[p],
               eb_data[p], eb_rdy[p]);
    end
    @(posedge clk);
    // Group A model keeps index 31 live (A1 uses it); A0's read rule hides it.
    if (wr_en) begin mem_a[wr_addr] = wr_data; pend_a[wr_addr] = 1'b0; end
    if (iss_en) pend_a[iss_addr] = 1'b1;
    if (b_wr_en && b_wr_addr < 5'd23) begin mem_b[b_wr_addr] = b_wr_data; pend_b[b_wr_addr] = 1'b0; end
    if (b_iss_en && b_iss_addr < 5'd23) pend_b[b_iss_addr] = 1'b1;
    #1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("b_data[%0d]", p), b_data[p], eb_data[p]);
      chk($sformatf("b_rdy[%0d]", p), 64'(b_rdy[p]), 64'(eb_rdy[p]));
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    rd_addr = '0;
    b_rd_addr = '0;
    clr_models();

    // Reset state of the registered instance
    @(posedge clk); #1;
    chk("b_rdy_reset", 64'(b_rdy), 64'hF);
    for (int p = 0; p < 4; p++) chk($sformatf("b_data_reset[%0d]", p), b_data[p], 64'd0);
    reset = 1'b0;

    // Every address reads zero and ready after reset
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = 5'(a);
      rd_addr[1] = 5'(31 - a);
      #1;
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("sweep_data[%0d]@%0d", p, a), a0_data[p], 64'd0);
        chk($sformatf("sweep_rdy[%0d]@%0d", p, a), 64'(a0_rdy[p]), 64'd1);
      end
    end
    @(posedge clk); #1;

    // Same-cycle bypass, then value from storage
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF_CAFEF00D; rd_addr[0] = 5'd5;
    #1 chk("r5_bypass", a0_data[0], 64'hDEADBEEF_CAFEF00D);
    do_cycle();
    wr_en = 1'b0;
    #1 chk("r5_mem", a0_data[0], 64'hDEADBEEF_CAFEF00D);
    do_cycle();

    // Zero register with and without XZR
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234;
    do_cycle();
    wr_en = 1'b0; rd_addr[0] = 5'd31;
    #1;
    chk("xzr_data", a0_data[0], 64'd0);
    chk("xzr_rdy", 64'(a0_rdy[0]), 64'd1);
    chk("r31_nozero", a1_data[0], 64'h1234);
    do_cycle();

    // Pending sequence on r7 read through port 1
    rd_addr[1] = 5'd7; iss_en = 1'b1; iss_addr = 5'd7;
    #1 chk("r7_rdy_issue_cycle", 64'(a0_rdy[1]), 64'd1);
    do_cycle();
    iss_en = 1'b0;
    #1 chk("r7_rdy_pending", 64'(a0_rdy[1]), 64'd0);
    do_cycle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h77;
    #1;
    chk("r7_rdy_bypass", 64'(a0_rdy[1]), 64'd1);
    chk("r7_data_bypass", a0_data[1], 64'h77);
    do_cycle();
    wr_en = 1'b0;
    #1 chk("r7_rdy_after", 64'(a0_rdy[1]), 64'd1);
    do_cycle();

    // Set wins over clear on r3
    rd_addr[0] = 5'd3; iss_en = 1'b1; iss_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h33;
    do_cycle();
    idle_inputs();
    #1;
    chk("r3_set_wins_rdy", 64'(a0_rdy[0]), 64'd0);
    chk("r3_data", a0_data[0], 64'h33);

    // Asynchronous reset mid-cycle; traffic during reset is discarded
    reset = 1'b1;
    iss_en = 1'b1; iss_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
    rd_addr[1] = 5'd4;
    wr_en = 1'b0;
    #1;
    chk("r3_rdy_reset", 64'(a0_rdy[0]), 64'd1);
    chk("r3_data_reset", a0_data[0], 64'd0);
    wr_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    clr_models();
    #1;
    chk("r4_rdy_after_reset", 64'(a0_rdy[1]), 64'd1);
    chk("r4_data_after_reset", a0_data[1], 64'd0);
    do_cycle();

    // Registered instance: out-of-range read, then 4-port read of a fresh write
    for (int p = 0; p < 4; p++) b_rd_addr[p] = 5'd30;
    do_cycle();
    chk("b_oob_data", b_data[0], 64'd0);
    chk("b_oob_rdy", 64'(b_rdy), 64'hF);
    b_wr_en = 1'b1; b_wr_addr = 5'd2; b_wr_data = 64'h55;
    for (int p = 0; p < 4; p++) b_rd_addr[p] = 5'd2;
    do_cycle();
    for (int p = 0; p < 4; p++) chk($sformatf("b_r2[%0d]", p), b_data[p], 64'h55);
    idle_inputs();
    do_cycle();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_addr  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 9));
      wr_data  = {$urandom, $urandom};
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = 5'($urandom_range(0, 9));
      for (int p = 0; p < 2; p++)
        rd_addr[p] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 9));
      b_wr_en    = ($urandom_range(0, 2) != 0);
      b_wr_addr  = 5'($urandom_range(0, 31));
      b_wr_data  = {$urandom, $urandom};
      b_iss_en   = ($urandom_range(0, 2) == 0);
      b_iss_addr = 5'($urandom_range(0, 31));
      for (int p = 0; p < 4; p++)
        b_rd_addr[p] = ($urandom_range(0, 3) == 0) ? b_wr_addr : 5'($urandom_range(0, 31));
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
